// File: rtl/timer_display_pkg.sv
// Shared constants and helpers for the MM.SS seven-segment display driver.
// Patterns are active-low {g,f,e,d,c,b,a}.
package timer_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Any code above 9 decodes to a dash; this is the one used for out-of-range fields.
  localparam logic [3:0] BCD_DASH = 4'hF;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return (v > 6'd59) ? BCD_DASH : 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return (v > 6'd59) ? BCD_DASH : 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/timer_display_seg7_decode.sv
// Combinational BCD to active-low seven-segment pattern; codes 10..15 show a dash.
module seg7_decode
  import timer_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// Four-digit multiplexed MM.SS display driver scanned from the 1 kHz strobe.
// Optional leading-zero blanking of the minutes tens digit: TIMER_DISPLAY_LZB_EN.
module timer_display
  import timer_display_pkg::*;
#(
  parameter int BLINK_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1k,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic             r_sync1, r_sync2, r_sync3;
  logic             r_started;
  digit_t           r_digit;
  logic [5:0]       r_min_snap, r_sec_snap;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_hidden;

  logic       w_tick;
  digit_t     w_next_digit;
  logic       w_enter_dig0;
  logic [5:0] w_min, w_sec;
  logic [3:0] w_code;
  logic       w_dp_n;
  logic       w_blank_lead;
  logic [6:0] w_dec_seg;
  logic [6:0] w_seg_next;
  logic [3:0] w_an_next;

  assign w_tick = r_sync2 & ~r_sync3;

  // The first tick after reset enters DIG0 rather than advancing past it.
  assign w_next_digit = r_started ? digit_t'(r_digit + 2'd1) : DIG0;
  assign w_enter_dig0 = (w_next_digit == DIG0);

  // The frame-opening tick decodes the values it is about to snapshot.
  assign w_min = w_enter_dig0 ? minutes : r_min_snap;
  assign w_sec = w_enter_dig0 ? seconds : r_sec_snap;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_code = bcd_ones(w_sec);
    w_dp_n = 1'b1;
    case (w_next_digit)
      DIG0: w_code = bcd_ones(w_sec);
      DIG1: w_code = bcd_tens(w_sec);
      DIG2: begin
        w_code = bcd_ones(w_min);
        w_dp_n = 1'b0;
      end
      DIG3: w_code = bcd_tens(w_min);
      default: w_code = BCD_DASH;
    endcase
  end

`ifdef TIMER_DISPLAY_LZB_EN
  assign w_blank_lead = (w_next_digit == DIG3) && (w_min < 6'd10);
`else
  assign w_blank_lead = 1'b0;
`endif

  seg7_decode u_decode (
    .i_bcd (w_code),
    .o_seg (w_dec_seg)
  );

  assign w_seg_next = w_blank_lead ? SEG_BLANK : w_dec_seg;
  assign w_an_next  = ~(4'b0001 << w_next_digit);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_started  <= 1'b0;
      r_digit    <= DIG0;
      r_min_snap <= '0;
      r_sec_snap <= '0;
      r_an       <= 4'b1111;
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b1;
    end else begin
      r_sync1 <= clk1k;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_tick) begin
        r_started <= 1'b1;
        r_digit   <= w_next_digit;
        r_an      <= w_an_next;
        r_seg     <= w_seg_next;
        r_dp      <= w_dp_n;
        if (w_enter_dig0) begin
          r_min_snap <= minutes;
          r_sec_snap <= seconds;
        end
      end
    end
  end

  // Blink phase clears as soon as blink drops, without waiting for a scan tick.
  always_ff @(posedge clk) begin
    if (rst || !blink) begin
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == CNT_W'(BLINK_TICKS - 1)) begin
        r_blink_cnt <= '0;
        r_hidden    <= ~r_hidden;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  assign an  = r_hidden ? 4'b1111 : r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display: directed scenarios plus randomized
// traffic checked against a frame-level reference model.
module tb_timer_display;

  localparam int BT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk1k;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  timer_display #(.BLINK_TICKS(BT)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk1k   (clk1k),
    .minutes (minutes),
    .seconds (seconds),
    .blink   (blink),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..9.
  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0]  DASH  = 7'b0111111;
  localparam logic [6:0]  BLANK = 7'b1111111;
  localparam logic [11:0] DARK  = 12'hFFF;

  // Reference model: scan position, frame snapshot, ticks seen while blinking.
  bit          m_started;
  int          m_idx, m_smin, m_ssec, m_n;
  logic [11:0] m_prev, pre_out, post_out;

  function automatic logic [11:0] model_out();
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    int         v;
    if (!m_started) return DARK;
    v = (m_idx < 2) ? m_ssec : m_smin;
    if (v > 59) s = DASH;
    else        s = glyph[(m_idx % 2 == 0) ? (v % 10) : (v / 10)];
`ifdef TIMER_DISPLAY_LZB_EN
    if (m_idx == 3 && m_smin < 10) s = BLANK;
`endif
    a = (((m_n / BT) % 2) == 1) ? 4'b1111 : ~(4'b0001 << m_idx);
    d = (m_idx == 2) ? 1'b0 : 1'b1;
    return {a, s, d};
  endfunction

  task automatic model_reset();
    m_started = 0; m_idx = 0; m_smin = 0; m_ssec = 0; m_n = 0;
  endtask

  task automatic model_tick();
    if (!m_started) begin
      m_started = 1;
      m_idx = 0;
    end else begin
      m_idx = (m_idx + 1) % 4;
    end
    if (m_idx == 0) begin
      m_smin = int'(minutes);
      m_ssec = int'(seconds);
    end
    if (blink) m_n++;
  endtask

  task automatic set_blink(input logic b);
    @(negedge clk);
    blink = b;
    if (!b) m_n = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clk1k period; captures outputs one edge before and at the expected update edge.
  task automatic apply_tick();
    m_prev = model_out();
    @(negedge clk);
    clk1k = 1'b1;
    repeat (2) @(posedge clk);
    #1 pre_out = {an, seg, dp};
    @(posedge clk);
    #1 post_out = {an, seg, dp};
    model_tick();
    repeat (3) @(negedge clk);
    clk1k = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    minutes = 6'd12; seconds = 6'd34; blink = 1'b0; clk1k = 1'b0;
    do_reset(3);
    #1;
    vectors++;
    if ({an, seg, dp} !== DARK) begin
      miscompares++;
      $display("FAIL reset_blank: got %h expected %h", {an, seg, dp}, DARK);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ({an, seg, dp} !== DARK) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", {an, seg, dp}, DARK);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int         exp_dg [4] = '{4, 3, 2, 1};
    logic [11:0] want;
    for (int i = 0; i < 4; i++) begin
      apply_tick();
      want = {exp_an[i], glyph[exp_dg[i]], (i == 2) ? 1'b0 : 1'b1};
      vectors += 2;
      if (pre_out !== m_prev) begin
        miscompares++;
        $display("FAIL scan_early[%0d]: got %h expected %h", i, pre_out, m_prev);
      end
      if (post_out !== want || post_out !== model_out()) begin
        miscompares++;
        $display("FAIL scan_digit[%0d]: got %h expected %h", i, post_out, want);
      end
    end
  endtask

  task automatic test_snapshot();
    repeat (2) apply_tick();               // now in DIG1
    @(negedge clk);
    seconds = 6'd35; minutes = 6'd13;
    for (int i = 0; i < 5; i++) begin
      apply_tick();
      vectors++;
      if (post_out !== model_out()) begin
        miscompares++;
        $display("FAIL snapshot[%0d]: got %h expected %h", i, post_out, model_out());
      end
      if (i == 0 || i == 2) begin
        vectors++;
        if (post_out[7:1] !== glyph[(i == 0) ? 2 : 5]) begin
          miscompares++;
          $display("FAIL snapshot_const[%0d]: got %b expected %b", i, post_out[7:1],
                   glyph[(i == 0) ? 2 : 5]);
        end
      end
    end
  endtask

  task automatic test_dash();
    @(negedge clk);
    minutes = 6'd12; seconds = 6'd60;
    for (int i = 0; i < 6; i++) begin
      apply_tick();
      vectors++;
      if (post_out !== model_out()) begin
        miscompares++;
        $display("FAIL dash[%0d]: got %h expected %h", i, post_out, model_out());
      end
      if (m_smin == 12 && m_ssec == 60) begin
        vectors++;
        if (post_out[7:1] !== ((m_idx < 2) ? DASH : glyph[(m_idx == 2) ? 2 : 1])) begin
          miscompares++;
          $display("FAIL dash_digit[%0d]: got %b idx %0d", i, post_out[7:1], m_idx);
        end
      end
    end
  endtask

  task automatic test_blink();
    int guard;
    @(negedge clk);
    seconds = 6'd34;
    set_blink(1'b1);
    for (int k = 1; k <= 16; k++) begin
      apply_tick();
      vectors++;
      if (post_out !== model_out() || (post_out[11:8] === 4'b1111) !== (((k / BT) % 2) == 1)) begin
        miscompares++;
        $display("FAIL blink[%0d]: got %h expected %h", k, post_out, model_out());
      end
    end
    guard = 0;
    while ((((m_n / BT) % 2) == 0) && guard < 8) begin
      apply_tick();
      guard++;
    end
    vectors++;
    if (an !== 4'b1111) begin
      miscompares++;
      $display("FAIL blink_hidden: got %b expected 1111", an);
    end
    set_blink(1'b0);
    @(posedge clk);
    #1;
    vectors++;
    if (an !== ~(4'b0001 << m_idx)) begin
      miscompares++;
      $display("FAIL blink_drop: got %b expected %b", an, ~(4'b0001 << m_idx));
    end
  endtask

  task automatic test_lzb();
    @(negedge clk);
    minutes = 6'd5; seconds = 6'd7;
    for (int i = 0; i < 8; i++) begin
      apply_tick();
      vectors++;
      if (post_out !== model_out()) begin
        miscompares++;
        $display("FAIL lzb[%0d]: got %h expected %h", i, post_out, model_out());
      end
      if (m_idx == 3 && m_smin == 5) begin
        vectors++;
`ifdef TIMER_DISPLAY_LZB_EN
        if (post_out[7:1] !== BLANK) begin
          miscompares++;
          $display("FAIL lzb_dig3: got %b expected %b", post_out[7:1], BLANK);
        end
`else
        if (post_out[7:1] !== glyph[0]) begin
          miscompares++;
          $display("FAIL lzb_dig3: got %b expected %b", post_out[7:1], glyph[0]);
        end
`endif
      end
    end
  endtask

  task automatic test_rst_mid();
    repeat (2) apply_tick();
    do_reset(1);
    #1;
    vectors++;
    if ({an, seg, dp} !== DARK) begin
      miscompares++;
      $display("FAIL rst_mid_blank: got %h expected %h", {an, seg, dp}, DARK);
    end
    apply_tick();
    vectors++;
    if (post_out[11:8] !== 4'b1110 || post_out !== model_out()) begin
      miscompares++;
      $display("FAIL rst_mid_restart: got %h expected %h", post_out, model_out());
    end
  endtask

  task automatic test_rst_tick();
    apply_tick();
    @(negedge clk);
    clk1k = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clk1k = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({an, seg, dp} !== DARK) begin
      miscompares++;
      $display("FAIL rst_tick_collide: got %h expected %h", {an, seg, dp}, DARK);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    vectors++;
    if ({an, seg, dp} !== DARK) begin
      miscompares++;
      $display("FAIL rst_tick_after: got %h expected %h", {an, seg, dp}, DARK);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) set_blink(~blink);
      apply_tick();
      vectors += 2;
      if (pre_out !== m_prev) begin
        miscompares++;
        $display("FAIL random_early[%0d]: got %h expected %h", i, pre_out, m_prev);
      end
      if (post_out !== model_out()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, post_out, model_out());
      end
    end
  endtask

  initial begin
    rst = 1'b0; clk1k = 1'b0; blink = 1'b0; minutes = '0; seconds = '0;
    model_reset();
    test_reset();
    test_scan();
    test_snapshot();
    test_dash();
    test_blink();
    test_lzb();
    test_rst_mid();
    test_rst_tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_display.md
Name: timer_display

Overview:
- Consumer end of the timer's time/blink output interface.
- Takes binary minutes/seconds plus the blink flag from the timer and drives a 4-digit, common-anode, time-multiplexed seven-segment display as MM.SS.
- Scan timing comes from the 1 kHz strobe already distributed to the timer.
- Sits between the timer and the board display pins.

Parameters:
- BLINK_TICKS, 500: scan ticks per blink half-period (500 ticks = 0.5 s at 1 kHz).
- NUM_DIGITS, 4: digit count; fixed at 4, present for the package constants only.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- clk1k  input  1  1 kHz scan strobe; asynchronous to clk, treated as data
- minutes  input  6  binary minutes from timer, 0..59 valid
- seconds  input  6  binary seconds from timer, 0..59 valid
- blink  input  1  timer-expired flag; display flashes while high
- an  output  4  digit anodes, active-low; an[0] = seconds ones
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; lit on digit 2 only (MM.SS separator)

Behaviour:
- Reset (rst high at a clk edge), all registers cleared:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Digit index=0, snapshot=0, blink counter=0, phase=visible.
  - Outputs stay blank until the first scan tick.
- Strobe handling:
  - clk1k passes through a 2-flop synchroniser plus one delay flop.
  - tick = sync2 & ~sync3, a one-clk pulse per clk1k rising edge.
  - Registered outputs update on the clk edge where tick is high.
  - Output change lands exactly 3 clk cycles after the clk1k rise as seen by clk.
- Scan FSM, states DIG0→DIG1→DIG2→DIG3→DIG0, advance one state per tick:
  - Each tick drives an for the new index (one bit low) and seg/dp for that digit.
  - No tick, no change.
- Snapshot: minutes/seconds are captured into internal registers only on the tick that enters DIG0. This prevents tearing within a scan frame.
- BCD conversion: tens = v/10, ones = v%10, combinational on the snapshot.
  - Value > 59 on either field: both digits of that field show dash (segment g only, seg=7'b0111111).
- Digit mapping:
  - DIG0 = seconds ones, DIG1 = seconds tens.
  - DIG2 = minutes ones, with dp=0.
  - DIG3 = minutes tens.
  - dp=1 on all other digits.
- Blink:
  - While blink=1, the counter increments per tick.
  - At BLINK_TICKS-1 the counter wraps to 0 and phase toggles.
  - Hidden phase: an=4'b1111 while seg/dp still track digits.
  - blink falling: counter=0 and phase=visible on the next clk edge, with no wait for a tick.
  - blink rising: the first hidden phase starts after BLINK_TICKS ticks (display starts visible).
- Simultaneous rst and tick: rst wins.
- rst mid-frame: immediate blank, restart at DIG0 on the next tick.

Optional Feature:
- Macro: TIMER_DISPLAY_LZB_EN (leading-zero blanking).
- Defined: minutes tens digit (DIG3) shows all segments off (seg=7'b1111111, an still scans) when the snapshot minutes < 10 and is not a dash.
- Undefined: DIG3 always shows its digit, including 0.

Decomposition:
- Package timer_display_pkg holds:
  - seg7 pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - typedef enum logic [1:0] digit_t {DIG0..DIG3}.
  - NUM_DIGITS.
- One sub-module, seg7_decode: combinational 4-bit BCD → 7-bit active-low pattern, with codes 10..15 giving SEG_DASH.
- BCD split and scan FSM stay in timer_display.

Test Plan:
- Reset: hold rst 3 clks → an=4'b1111, seg=7'b1111111, dp=1, unchanged until first clk1k rise.
- minutes=12, seconds=34, blink=0, 4 clk1k periods → observe, in order:
  - an=1110, seg=SEG_4
  - an=1101, SEG_3
  - an=1011, SEG_2, dp=0
  - an=0111, SEG_1
  - Each transition occurs 3 clks after the clk1k rise.
- Snapshot: change seconds 34→35 while in DIG1 → DIG0 still shows 4 until the next frame, then 5.
- seconds=60 → DIG0/DIG1 seg=7'b0111111; minutes digits unaffected.
- blink=1 with BLINK_TICKS=4 override, 16 ticks → an visible 4 ticks, 1111 for 4 ticks, repeating; drop blink during the hidden phase → an drives again on the next clk.
- With TIMER_DISPLAY_LZB_EN, minutes=5 → DIG3 seg=7'b1111111; without it → SEG_0.
